// File: rtl/digit_serial_addsub.sv
// rtl/digit_serial_addsub.sv - digit-serial add/subtract with ripple carry held between beats and valid/ready on both sides.
// Define ADDSUB_SATURATE_EN to clamp Sum on signed overflow; left undefined, Sum wraps.
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             CarryIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam int NBEATS = WIDTH / DIGIT;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             rstDone;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic             carry;
  logic [CW-1:0]    beat;
  logic             aMsb;
  logic             bMsb;
  logic [DIGIT-1:0] digitSum;
  logic             digitCarry;
  logic [WIDTH-1:0] fullSum;
  logic [WIDTH-1:0] finalSum;
  logic             ovf;
  logic             lastBeat;

  assign {digitCarry, digitSum} = {1'b0, aReg[DIGIT-1:0]} + {1'b0, bReg[DIGIT-1:0]}
                                + {{DIGIT{1'b0}}, carry};
  assign lastBeat = (beat == CW'(NBEATS - 1));

  // Earlier digits are shifted in from the top, so after the last beat the
  // full result is the current digit stacked above the partial register.
  generate
    if (DIGIT == WIDTH) begin : gSingle
      assign fullSum = digitSum;
    end else begin : gMulti
      logic [WIDTH-DIGIT-1:0] resReg;
      always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
          resReg <= '0;
        end else if (state == BUSY) begin
          resReg <= fullSum[WIDTH-1:DIGIT];
        end
      end
      assign fullSum = {digitSum, resReg};
    end
  endgenerate

  assign ovf = (aMsb == bMsb) && (fullSum[WIDTH-1] != aMsb);

`ifdef ADDSUB_SATURATE_EN
  assign finalSum = ovf ? {aMsb, {(WIDTH-1){~aMsb}}} : fullSum;
`else
  assign finalSum = fullSum;
`endif

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      rstDone  <= 1'b0;
      aReg     <= '0;
      bReg     <= '0;
      carry    <= 1'b0;
      beat     <= '0;
      aMsb     <= 1'b0;
      bMsb     <= 1'b0;
      Sum      <= '0;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      rstDone <= 1'b1;
      case (state)
        IDLE: begin
          if (InValid && rstDone) begin
            aReg  <= A;
            bReg  <= Sub ? ~B : B;
            carry <= Sub ? ~CarryIn : CarryIn;
            aMsb  <= A[WIDTH-1];
            bMsb  <= Sub ? ~B[WIDTH-1] : B[WIDTH-1];
            beat  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          aReg  <= aReg >> DIGIT;
          bReg  <= bReg >> DIGIT;
          carry <= digitCarry;
          beat  <= beat + 1'b1;
          if (lastBeat) begin
            Sum      <= finalSum;
            CarryOut <= digitCarry;
            Overflow <= ovf;
            state    <= DONE;
          end
        end
        DONE: begin
          if (OutReady) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign InReady  = (state == IDLE) && rstDone;
  assign OutValid = (state == DONE);

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb/tb_digit_serial_addsub.sv - self-checking bench for digit_serial_addsub against an integer-arithmetic model.
module tb_digit_serial_addsub;
  localparam int WIDTH  = 16;
  localparam int DIGIT  = 4;
  localparam int NBEATS = WIDTH / DIGIT;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Sub = 1'b0;
  logic        CarryIn = 1'b0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [15:0] Sum;
  logic        CarryOut;
  logic        Overflow;

  int checks = 0;
  int errors = 0;

  digit_serial_addsub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .Clock(Clock), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
    .A(A), .B(B), .Sub(Sub), .CarryIn(CarryIn), .OutValid(OutValid),
    .OutReady(OutReady), .Sum(Sum), .CarryOut(CarryOut), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  // Returns {carryOut, overflow, sum} from signed/unsigned integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic cin);
    int sa, sb, res;
    logic [15:0] s;
    logic co, ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      res = sa + sb + int'(cin);
      co  = (int'(a) + int'(b) + int'(cin)) > 65535;
    end else begin
      res = sa - sb - int'(cin);
      co  = int'(a) >= (int'(b) + int'(cin));
    end
    ov = (res > 32767) || (res < -32768);
    s  = res[15:0];
`ifdef ADDSUB_SATURATE_EN
    if (ov) s = (res > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {co, ov, s};
  endfunction

  // Entered and left on a negedge with the DUT idle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic cin, input int stall, input bit poke, input string name);
    logic [17:0] exp;
    int n;
    exp = model(a, b, sub, cin);
    n = 0;
    while (InReady !== 1'b1 && n < 50) begin
      @(posedge Clock); @(negedge Clock); n++;
    end
    checks++;
    if (InReady !== 1'b1) begin
      errors++; $display("FAIL %s ready_timeout: InReady=%b required 1", name, InReady);
    end
    A = a; B = b; Sub = sub; CarryIn = cin; InValid = 1'b1;
    @(posedge Clock); @(negedge Clock);
    InValid = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Sub = 1'($urandom); CarryIn = 1'($urandom);
    n = 0;
    while (OutValid !== 1'b1 && n < 50) begin
      @(posedge Clock); @(negedge Clock); n++;
    end
    checks++;
    if (n != NBEATS) begin
      errors++; $display("FAIL %s latency: got %0d cycles required %0d", name, n, NBEATS);
    end
    checks++;
    if ({CarryOut, Overflow, Sum} !== exp) begin
      errors++;
      $display("FAIL %s result: got co=%b ov=%b sum=%h required co=%b ov=%b sum=%h",
               name, CarryOut, Overflow, Sum, exp[17], exp[16], exp[15:0]);
    end
    OutReady = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        InValid = 1'b1; A = 16'($urandom); B = 16'($urandom);
      end
      @(posedge Clock); @(negedge Clock);
      checks++;
      if ({OutValid, InReady, CarryOut, Overflow, Sum} !== {2'b10, exp}) begin
        errors++;
        $display("FAIL %s hold: got v=%b r=%b co=%b ov=%b sum=%h required v=1 r=0 sum=%h",
                 name, OutValid, InReady, CarryOut, Overflow, Sum, exp[15:0]);
      end
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    @(posedge Clock); @(negedge Clock);
    OutReady = 1'b0;
    checks++;
    if ({OutValid, InReady} !== 2'b01) begin
      errors++; $display("FAIL %s release: got v=%b r=%b required v=0 r=1", name, OutValid, InReady);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({InReady, OutValid, CarryOut, Overflow, Sum} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: got r=%b v=%b co=%b ov=%b sum=%h required all 0",
               InReady, OutValid, CarryOut, Overflow, Sum);
    end
    @(negedge Clock); @(negedge Clock);
    ResetN = 1'b1;
    #1;
    checks++;
    if (InReady !== 1'b0) begin
      errors++; $display("FAIL reset_release_ready: got %b required 0", InReady);
    end
    @(posedge Clock); @(negedge Clock);
    checks++;
    if (InReady !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after: got %b required 1", InReady);
    end
  endtask

  task automatic test_directed();
    run_op(16'h000F, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "add_carry_chain");
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 0, 1'b0, "sub_borrow");
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0, "sub_borrow_in");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "pos_overflow");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 0, 1'b0, "neg_overflow");
    run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 0, 1'b0, "add_carry_in");
  endtask

  task automatic test_backpressure();
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 10, 1'b1, "backpressure");
  endtask

  task automatic test_reset_midop();
    int n;
    n = 0;
    while (InReady !== 1'b1 && n < 50) begin
      @(posedge Clock); @(negedge Clock); n++;
    end
    A = 16'hABCD; B = 16'h1357; Sub = 1'b0; CarryIn = 1'b1; InValid = 1'b1;
    @(posedge Clock); @(negedge Clock);
    InValid = 1'b0;
    @(posedge Clock); @(negedge Clock);
    ResetN = 1'b0;
    #1;
    checks++;
    if ({InReady, OutValid, CarryOut, Overflow, Sum} !== 20'h0) begin
      errors++;
      $display("FAIL midop_reset: got r=%b v=%b co=%b ov=%b sum=%h required all 0",
               InReady, OutValid, CarryOut, Overflow, Sum);
    end
    @(negedge Clock);
    ResetN = 1'b1;
    @(posedge Clock); @(negedge Clock);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [17:0] q[$];
    int acc[$];
    logic [17:0] e;
    OutReady = 1'b1;
    InValid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (OutValid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious: OutValid=1 with no pending operation");
        end else begin
          e = q.pop_front();
          if ({CarryOut, Overflow, Sum} !== e) begin
            errors++;
            $display("FAIL b2b_result: got co=%b ov=%b sum=%h required co=%b ov=%b sum=%h",
                     CarryOut, Overflow, Sum, e[17], e[16], e[15:0]);
          end
        end
      end
      A = 16'($urandom); B = 16'($urandom); Sub = 1'($urandom); CarryIn = 1'($urandom);
      if (InReady === 1'b1) begin
        q.push_back(model(A, B, Sub, CarryIn));
        acc.push_back(i);
      end
      @(posedge Clock); @(negedge Clock);
    end
    InValid = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      if (OutValid === 1'b1) begin
        e = q.pop_front();
        checks++;
        if ({CarryOut, Overflow, Sum} !== e) begin
          errors++;
          $display("FAIL b2b_drain: got co=%b ov=%b sum=%h required co=%b ov=%b sum=%h",
                   CarryOut, Overflow, Sum, e[17], e[16], e[15:0]);
        end
      end
      @(posedge Clock); @(negedge Clock);
    end
    OutReady = 1'b0;
    checks++;
    if (q.size() != 0 || acc.size() < 6) begin
      errors++;
      $display("FAIL b2b_count: got accepted=%0d pending=%0d required accepted>=6 pending=0",
               acc.size(), q.size());
    end
    for (int k = 1; k < acc.size(); k++) begin
      checks++;
      if (acc[k] - acc[k-1] != NBEATS + 2) begin
        errors++;
        $display("FAIL b2b_interval: got %0d cycles required %0d", acc[k] - acc[k-1], NBEATS + 2);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
